battle_roll: RTL
================

# battle_roll

Parametrised attack-resolution engine for the battle system. It harvests entropy bits from the ring-oscillator sources into a 16-bit Galois LFSR, draws a WIDTH-bit roll on request, and compares the roll against a hit threshold. On a hit it applies saturating damage to an internal HP register. The block replaces ad-hoc HP/RNG glue at the top level, sitting between the ring-oscillator sources and the battle display/controller logic.

## Interface
Parameters:
- WIDTH, 4: roll width in bits (1..16)
- HP_WIDTH, 4: HP/damage width in bits
- HP_INIT, 9: HP value after reset
- N_ENT, 4: number of entropy input bits (1..16)
- SEED, 16'hACE1: LFSR value after reset and on zero-lock recovery (must be nonzero)

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- reset  in  1  asynchronous, active-low reset
- ent  in  N_ENT  raw ring-oscillator bits, asynchronous to clk
- mix_en  in  1  1 = fold synchronised entropy into LFSR each cycle
- req  in  1  roll request, sampled only in IDLE
- threshold  in  WIDTH  hit when roll >= threshold
- dmg  in  HP_WIDTH  damage applied on hit, sampled in DRAW
- hp_load  in  1  load HP from hp_load_val, honoured only in IDLE
- hp_load_val  in  HP_WIDTH  HP load value
- busy  out  1  high in DRAW/APPLY/DONE
- valid  out  1  one-cycle pulse in DONE; roll/hit/hp final
- hit  out  1  result of last completed roll
- roll  out  WIDTH  last drawn roll
- hp  out  HP_WIDTH  current HP
- fainted  out  1  hp == 0 (combinational from hp register)
- hit_count  out  8  hits since reset, saturates at 255

## Operation
- Entropy path: ent passes through a two-flop synchroniser per bit (reset 0). With mix_en=1, lfsr_next = galois(lfsr) ^ {zero-extend sync_ent}. With mix_en=0, lfsr_next = galois(lfsr).
- galois(s): shift right one bit; if the old s[0] was 1, XOR the result with 16'hB400.
- Zero-lock: if lfsr_next == 0, load SEED instead. The LFSR is never 0.
- The LFSR advances every cycle in every state.
- FSM states: IDLE, DRAW, APPLY, DONE.
  - IDLE: if hp_load, hp <= hp_load_val and stay in IDLE; else if req, go to DRAW. hp_load has priority over req in the same cycle.
  - DRAW: roll <= lfsr[WIDTH-1:0]; latch dmg and threshold internally; go to APPLY.
  - APPLY: hit <= (roll >= thr_latched). On hit: hp <= (hp > dmg_latched) ? hp - dmg_latched : 0, and hit_count increments unless already 255. Go to DONE.
  - DONE: valid=1; go to IDLE.
- Requests arriving in DRAW/APPLY/DONE are dropped, not queued. hp_load outside IDLE is ignored.
- A fainted state does not block requests: the roll and hit still resolve, and hp stays 0.
- Arithmetic is unsigned with no wrap. dmg=0 with a hit leaves hp unchanged but still counts the hit.

## Timing
- Reset (asynchronous assert, synchronous to clk on deassert edge use):
  - lfsr=SEED, state=IDLE, roll=0, hit=0, valid=0, busy=0
  - hp=HP_INIT, hit_count=0, synchroniser flops=0
- Latency: req high at rising edge k (in IDLE) gives:
  - busy high after edge k
  - roll updated at edge k+1
  - hit/hp/hit_count updated at edge k+2
  - valid high for exactly the cycle after edge k+2, cleared at k+3
- Minimum spacing between accepted requests is 4 cycles. With req held high continuously, a new roll starts every 4 cycles.
- Entropy latency: an ent change affects the LFSR no earlier than 3 edges later (2 synchroniser edges plus the mixing edge).
- Reset asserted mid-roll (any state): immediate return to reset values, no valid pulse, no partial HP update.
- hit and roll hold their values until the next roll. valid is the only pulse output.

## Test plan
- Reset: release reset with HP_INIT=9 -> hp=9, fainted=0, valid=0, busy=0, hit_count=0, roll=0.
- Damage sequence: threshold=0, dmg=4, mix_en=0, three requests 4 cycles apart -> each valid has hit=1, hp goes 5, 1, 0; fainted=1 after the third; a fourth request gives hit=1, hp=0, hit_count=4.
- Handshake: req at edge k, then req again at k+1 and k+2 -> exactly one valid, at cycle k+3; busy high for 3 cycles. hp_load=1 with hp_load_val=12 and req in the same IDLE cycle -> hp=12, no roll, busy stays 0.
- Reset mid-roll: assert reset while in APPLY with hp=9, dmg=3 -> hp=9, no valid pulse, state IDLE after release.
- Determinism and zero-lock:
  - mix_en=0: two runs from reset with identical req timing -> identical roll sequences.
  - threshold=15, WIDTH=4 -> hit only when roll == 15.
  - mix_en=1 with random ent for 100k cycles -> LFSR never 0 (assertion).
- Saturation: force 300 hits (threshold=0, dmg=0) -> hit_count stops at 255; hp is unchanged throughout.

Source files
------------

// File: rtl/battle_roll.sv
// battle_roll
//   Attack-resolution engine. Ring-oscillator entropy is synchronised and
//   folded into a 16-bit Galois LFSR. On request the block draws a WIDTH-bit
//   roll and compares it with a hit threshold. On a hit it applies saturating
//   damage to an internal HP register and bumps a saturating hit counter.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   ent          raw ring-oscillator bits, asynchronous to clk
//   mix_en       1 = fold synchronised entropy into the LFSR every cycle
//   req          roll request, only looked at in IDLE
//   threshold    hit when roll >= threshold (captured in DRAW)
//   dmg          damage applied on a hit (captured in DRAW)
//   hp_load      load hp from hp_load_val, only honoured in IDLE
//   hp_load_val  HP load value
//   busy         high while a roll is in flight (DRAW/APPLY/DONE)
//   valid        one-cycle pulse in DONE; roll/hit/hp are final
//   hit          result of the last completed roll
//   roll         last drawn roll
//   hp           current HP
//   fainted      hp == 0
//   hit_count    hits since reset, saturating at 255
module battle_roll #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned HP_WIDTH = 4,
  parameter int unsigned HP_INIT  = 9,
  parameter int unsigned N_ENT    = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_ENT-1:0]    ent,
  input  logic                mix_en,
  input  logic                req,
  input  logic [WIDTH-1:0]    threshold,
  input  logic [HP_WIDTH-1:0] dmg,
  input  logic                hp_load,
  input  logic [HP_WIDTH-1:0] hp_load_val,
  output logic                busy,
  output logic                valid,
  output logic                hit,
  output logic [WIDTH-1:0]    roll,
  output logic [HP_WIDTH-1:0] hp,
  output logic                fainted,
  output logic [7:0]          hit_count
);

  localparam logic [15:0]         TAPS     = 16'hB400;
  localparam logic [HP_WIDTH-1:0] HP_RESET = HP_WIDTH'(HP_INIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [N_ENT-1:0]    ent_meta_q, ent_meta_d;
  logic [N_ENT-1:0]    ent_sync_q, ent_sync_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [WIDTH-1:0]    roll_q, roll_d;
  logic [WIDTH-1:0]    thr_q, thr_d;
  logic [HP_WIDTH-1:0] dmg_q, dmg_d;
  logic                hit_q, hit_d;
  logic [HP_WIDTH-1:0] hp_q, hp_d;
  logic [7:0]          hit_count_q, hit_count_d;

  // Entropy synchroniser and LFSR step. The LFSR runs every cycle regardless
  // of FSM state, so the roll depends on when the request lands.
  always_comb begin
    logic [15:0] shifted;
    ent_meta_d = ent;
    ent_sync_d = ent_meta_q;
    shifted    = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      shifted = shifted ^ TAPS;
    end
    if (mix_en) begin
      shifted = shifted ^ 16'(ent_sync_q);
    end
    // Entropy mixing can cancel the state to zero, which would lock the
    // LFSR forever; reseed instead.
    lfsr_d = (shifted == 16'h0000) ? SEED : shifted;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_meta_q <= '0;
      ent_sync_q <= '0;
      lfsr_q     <= SEED;
    end else begin
      ent_meta_q <= ent_meta_d;
      ent_sync_q <= ent_sync_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; an HP load in IDLE takes priority over a request, and
  // requests outside IDLE are simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!hp_load && req) begin
          state_d = DRAW;
        end
      end
      DRAW:    state_d = APPLY;
      APPLY:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy  = (state_q != IDLE);
    valid = (state_q == DONE);
  end

  // Datapath: threshold and damage are captured in DRAW so the caller may
  // change them while the roll resolves.
  always_comb begin
    roll_d      = roll_q;
    thr_d       = thr_q;
    dmg_d       = dmg_q;
    hit_d       = hit_q;
    hp_d        = hp_q;
    hit_count_d = hit_count_q;
    case (state_q)
      IDLE: begin
        if (hp_load) begin
          hp_d = hp_load_val;
        end
      end
      DRAW: begin
        roll_d = lfsr_q[WIDTH-1:0];
        thr_d  = threshold;
        dmg_d  = dmg;
      end
      APPLY: begin
        hit_d = (roll_q >= thr_q);
        if (hit_d) begin
          hp_d = (hp_q > dmg_q) ? (hp_q - dmg_q) : '0;
          if (hit_count_q != 8'hFF) begin
            hit_count_d = hit_count_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      roll_q      <= '0;
      thr_q       <= '0;
      dmg_q       <= '0;
      hit_q       <= 1'b0;
      hp_q        <= HP_RESET;
      hit_count_q <= '0;
    end else begin
      roll_q      <= roll_d;
      thr_q       <= thr_d;
      dmg_q       <= dmg_d;
      hit_q       <= hit_d;
      hp_q        <= hp_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign hit       = hit_q;
  assign roll      = roll_q;
  assign hp        = hp_q;
  assign fainted   = (hp_q == '0);
  assign hit_count = hit_count_q;

endmodule
